fir_decim_sink: RTL and testbench

- Downstream stage of the 9-tap FIR: consumes the 24-bit filter output stream.
- Discards the filter fill-up transient, then averages non-overlapping blocks of 2^LOG2_DECIM samples.
- Rounds and scales each average to OUT_W bits.
- Buffers results in a small FIFO behind a valid/ready interface, so a slower consumer can drain them without stalling the FIR.

---
 rtl/fir_decim_sink.sv | 152 +++++++++++++++
 tb/tb_fir_decim_sink.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/fir_decim_sink.sv
// Decimating block averager behind the 9-tap FIR: drops the fill-up transient, averages
// blocks of 2^LOG2_DECIM samples, and queues rounded results. Option: FIR_DECIM_SAT_EN.
module fir_decim_sink #(
  parameter int unsigned IN_W       = 24,
  parameter int unsigned OUT_W      = 16,
  parameter int unsigned LOG2_DECIM = 2,
  parameter int unsigned DROP_LSB   = 4,
  parameter int unsigned HOLDOFF    = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  input  logic [IN_W-1:0]  in_data_i,
  output logic [OUT_W-1:0] out_data_o,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             overflow_o,
  input  logic             clr_ovf_i,
  output logic             holdoff_done_o
);

  localparam int unsigned AccW  = IN_W + LOG2_DECIM + 1;
  localparam int unsigned Shift = LOG2_DECIM + DROP_LSB;
  localparam int unsigned CntW  = (LOG2_DECIM == 0) ? 1 : LOG2_DECIM;
  localparam int unsigned HoldW = (HOLDOFF == 0) ? 1 : $clog2(HOLDOFF + 1);
  localparam int unsigned PtrW  = $clog2(FIFO_DEPTH);
  localparam int unsigned OccW  = $clog2(FIFO_DEPTH + 1);

  localparam logic [CntW-1:0]  LastIdx  = CntW'((1 << LOG2_DECIM) - 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLDOFF - 1);
  localparam logic [AccW-1:0]  Round    = (Shift == 0) ? '0 : (AccW'(1) << (Shift - 1));
  localparam logic [OccW-1:0]  OccFull  = OccW'(FIFO_DEPTH);

  typedef enum logic [0:0] {StFill, StAcc} state_e;

  // With no holdoff the block starts averaging straight out of reset.
  localparam state_e StReset  = (HOLDOFF == 0) ? StAcc : StFill;
  localparam logic   HdReset  = (HOLDOFF == 0);

  state_e           state_q, state_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic             hd_q, hd_d;
  logic [CntW-1:0]  samp_cnt_q, samp_cnt_d;
  logic [AccW-1:0]  acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [OccW-1:0]  occ_q, occ_d;
  logic [OUT_W-1:0] mem_q [FIFO_DEPTH];

  logic [AccW-1:0]  sum_w, res_w;
  logic [OUT_W-1:0] push_data;
  logic             push, pop, full, push_ok, drop;

  assign sum_w = acc_q + AccW'(in_data_i) + Round;
  assign res_w = sum_w >> Shift;

`ifdef FIR_DECIM_SAT_EN
  assign push_data = ((res_w >> OUT_W) != '0) ? '1 : OUT_W'(res_w);
`else
  assign push_data = OUT_W'(res_w);
`endif

  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    hd_d       = hd_q;
    samp_cnt_d = samp_cnt_q;
    acc_d      = acc_q;
    push       = 1'b0;
    unique case (state_q)
      StFill: begin
        if (in_valid_i) begin
          hold_cnt_d = hold_cnt_q + HoldW'(1);
          if (hold_cnt_q == HoldLast) begin
            state_d = StAcc;
            hd_d    = 1'b1;
          end
        end
      end
      StAcc: begin
        if (in_valid_i) begin
          if (samp_cnt_q == LastIdx) begin
            acc_d      = '0;
            samp_cnt_d = '0;
            push       = 1'b1;
          end else begin
            acc_d      = acc_q + AccW'(in_data_i);
            samp_cnt_d = samp_cnt_q + CntW'(1);
          end
        end
      end
    endcase
  end

  assign out_valid_o = (occ_q != '0);
  assign pop         = out_valid_o && out_ready_i;
  assign full        = (occ_q == OccFull);
  // A full FIFO still takes a push when the head leaves on the same edge.
  assign push_ok     = push && (!full || pop);
  assign drop        = push && full && !pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (pop)     rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (push_ok && !pop)      occ_d = occ_q + OccW'(1);
    else if (!push_ok && pop) occ_d = occ_q - OccW'(1);
    ovf_d = ovf_q;
    if (drop)           ovf_d = 1'b1;
    else if (clr_ovf_i) ovf_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StReset;
      hold_cnt_q <= '0;
      hd_q       <= HdReset;
      samp_cnt_q <= '0;
      acc_q      <= '0;
      ovf_q      <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
    end else begin
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      hd_q       <= hd_d;
      samp_cnt_q <= samp_cnt_d;
      acc_q      <= acc_d;
      ovf_q      <= ovf_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  assign out_data_o     = mem_q[rd_ptr_q];
  assign overflow_o     = ovf_q;
  assign holdoff_done_o = hd_q;

endmodule

// File: tb/tb_fir_decim_sink.sv
// Directed bench for fir_decim_sink: holdoff, averaging, saturation/truncation,
// FIFO backpressure and overflow, idle gaps and mid-block reset.
module tb_fir_decim_sink;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        in_valid_i;
  logic [23:0] in_data_i;
  logic [15:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        overflow_o;
  logic        clr_ovf_i;
  logic        holdoff_done_o;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  fir_decim_sink dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .in_valid_i     (in_valid_i),
    .in_data_i      (in_data_i),
    .out_data_o     (out_data_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .overflow_o     (overflow_o),
    .clr_ovf_i      (clr_ovf_i),
    .holdoff_done_o (holdoff_done_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered at a negedge: drive, let the posedge pass, return at the next negedge.
  task automatic cycle(input logic v, input logic [23:0] d);
    in_valid_i = v;
    in_data_i  = d;
    @(negedge clk_i);
  endtask

  task automatic blk(input logic [23:0] d);
    repeat (4) cycle(1'b1, d);
  endtask

  task automatic do_reset();
    rst_ni     = 1'b0;
    in_valid_i = 1'b0;
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  logic [15:0] sat_exp;
  logic [15:0] exp_q [4];
  int          nval;

  initial begin
`ifdef FIR_DECIM_SAT_EN
    sat_exp = 16'hFFFF;
`else
    sat_exp = 16'h0000;
`endif
    rst_ni      = 1'b0;
    in_valid_i  = 1'b0;
    in_data_i   = '0;
    out_ready_i = 1'b0;
    clr_ovf_i   = 1'b0;
    @(negedge clk_i);
    check("rst_out_valid", 32'(out_valid_o), 32'd0);
    check("rst_out_data", 32'(out_data_o), 32'd0);
    check("rst_overflow", 32'(overflow_o), 32'd0);
    check("rst_holdoff_done", 32'(holdoff_done_o), 32'd0);
    rst_ni = 1'b1;

    // Holdoff then one average of 1000: (4000+32)>>6 = 63
    out_ready_i = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      cycle(1'b1, 24'd1000);
      if (i == 7) check("hd_after7", 32'(holdoff_done_o), 32'd0);
      if (i == 8) check("hd_after8", 32'(holdoff_done_o), 32'd1);
      if (i == 11) check("no_valid_early", 32'(out_valid_o), 32'd0);
    end
    check("avg_valid", 32'(out_valid_o), 32'd1);
    check("avg_data", 32'(out_data_o), 32'd63);
    cycle(1'b0, 24'd0);
    check("avg_popped", 32'(out_valid_o), 32'd0);

    // Full-scale block: res = 20'h100000
    blk(24'hFFFFFF);
    check("sat_valid", 32'(out_valid_o), 32'd1);
    check("sat_data", 32'(out_data_o), 32'(sat_exp));
    cycle(1'b0, 24'd0);

    // Backpressure: four results fit, fifth is dropped
    out_ready_i = 1'b0;
    blk(24'd160); blk(24'd320); blk(24'd480); blk(24'd640);
    check("bp_head", 32'(out_data_o), 32'd10);
    check("bp_no_ovf", 32'(overflow_o), 32'd0);
    blk(24'd800);
    check("bp_ovf_set", 32'(overflow_o), 32'd1);
    check("bp_head_kept", 32'(out_data_o), 32'd10);
    exp_q = '{16'd10, 16'd20, 16'd30, 16'd40};
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("bp_valid", 32'(out_valid_o), 32'd1);
      check("bp_pop_data", 32'(out_data_o), 32'(exp_q[i]));
      cycle(1'b0, 24'd0);
    end
    check("bp_drained", 32'(out_valid_o), 32'd0);
    check("bp_ovf_sticky", 32'(overflow_o), 32'd1);
    clr_ovf_i = 1'b1;
    cycle(1'b0, 24'd0);
    clr_ovf_i = 1'b0;
    check("ovf_cleared", 32'(overflow_o), 32'd0);

    // Full FIFO with pop on the completing edge: push accepted
    out_ready_i = 1'b0;
    blk(24'd160); blk(24'd320); blk(24'd480); blk(24'd640);
    repeat (3) cycle(1'b1, 24'd800);
    out_ready_i = 1'b1;
    cycle(1'b1, 24'd800);
    out_ready_i = 1'b0;
    check("pp_no_ovf", 32'(overflow_o), 32'd0);
    exp_q = '{16'd20, 16'd30, 16'd40, 16'd50};
    out_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("pp_valid", 32'(out_valid_o), 32'd1);
      check("pp_pop_data", 32'(out_data_o), 32'(exp_q[i]));
      cycle(1'b0, 24'd0);
    end
    check("pp_drained", 32'(out_valid_o), 32'd0);

    // Idle gaps with junk data on invalid cycles
    do_reset();
    nval = 0;
    for (int i = 0; i < 24; i++) begin
      if (i % 2 == 0) begin
        cycle(1'b1, 24'd1000);
        nval++;
        if (nval == 7) check("gap_hd7", 32'(holdoff_done_o), 32'd0);
        if (nval == 8) check("gap_hd8", 32'(holdoff_done_o), 32'd1);
        if (nval == 11) check("gap_no_valid", 32'(out_valid_o), 32'd0);
        if (nval == 12) begin
          check("gap_valid", 32'(out_valid_o), 32'd1);
          check("gap_data", 32'(out_data_o), 32'd63);
        end
      end else begin
        cycle(1'b0, 24'h5A5A5A);
      end
    end
    check("gap_popped", 32'(out_valid_o), 32'd0);

    // Reset mid-block with two results queued
    out_ready_i = 1'b0;
    blk(24'd160); blk(24'd320);
    cycle(1'b1, 24'd1000); cycle(1'b1, 24'd1000);
    check("mr_queued", 32'(out_valid_o), 32'd1);
    rst_ni = 1'b0;
    in_valid_i = 1'b0;
    #1;
    check("mr_valid_clr", 32'(out_valid_o), 32'd0);
    check("mr_hd_clr", 32'(holdoff_done_o), 32'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      cycle(1'b1, 24'd500);
      if (i == 7) check("mr_hd7", 32'(holdoff_done_o), 32'd0);
    end
    check("mr_hd8", 32'(holdoff_done_o), 32'd1);
    check("mr_no_valid", 32'(out_valid_o), 32'd0);
    blk(24'd2000);
    check("mr_valid", 32'(out_valid_o), 32'd1);
    check("mr_data", 32'(out_data_o), 32'd125);
    out_ready_i = 1'b1;
    cycle(1'b0, 24'd0);
    check("mr_popped", 32'(out_valid_o), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
